// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel deserializer: a 1-bit stream is steered into 8 registered lanes
// by an internal lane counter, and the finished byte is handed off with valid/ready.
module demux_1to8_deser #(
    parameter int LANES     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     sync,
    output logic [LANES-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(LANES)-1:0] lane
);
    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, wr_lane, lane_nxt;
    logic [LANES-1:0] dout_nxt;
    logic             valid_nxt;
    logic             accept;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        valid_nxt = dout_valid;
        // Ready never looks at din, so there is no din-to-dout combinational path.
        din_ready = (state == FILL) || dout_ready;
        accept    = din_valid && din_ready;
        wr_lane   = MSB_FIRST ? ~cnt : cnt;

        if (state == HOLD && dout_ready) begin
            state_nxt = FILL;
            valid_nxt = 1'b0;
        end

        // A bit arriving with sync is dropped so the next byte starts cleanly at lane 0.
        if (sync) begin
            cnt_nxt = '0;
        end else if (accept) begin
            dout_nxt[wr_lane] = din;
            if (cnt == LAST) begin
                cnt_nxt   = '0;
                state_nxt = HOLD;
                valid_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        lane_nxt = MSB_FIRST ? ~cnt_nxt : cnt_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            lane       <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt;
            lane       <= lane_nxt;
        end
    end
endmodule
